// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, requests instruction memory over
// a valid handshake, and loads the IF/ID register consumed by decode. Decode
// stalls are absorbed by a one-entry skid buffer. Redirects from execute that
// arrive while a memory response is still outstanding are handled by draining
// that response in the DROP state.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemRdata,
    input  logic        imemValid,
    input  logic        stallD,
    input  logic        pcSrcE,
    input  logic [31:0] pcTargetE,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic [31:0] pcPlus4D,
    output logic        validD
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        SKID  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pcF_q, pcF_d;
    logic [31:0] skidInstr_q, skidInstr_d;
    logic [31:0] skidPc_q, skidPc_d;
    logic [31:0] pendingPc_q, pendingPc_d;
    logic [31:0] instrD_q, instrD_d;
    logic [31:0] pcD_q, pcD_d;
    logic [31:0] pcPlus4D_q, pcPlus4D_d;
    logic        validD_q, validD_d;

    logic        accept;
    logic        ready;
    logic        loadEn;
    logic [31:0] loadInstr;
    logic [31:0] loadPc;

    // The address never moves while a request is outstanding, because pcF only
    // advances on accept (and in DROP it still holds the outstanding address).
    assign imemReq  = rst_n && ((state_q == FETCH) || (state_q == DROP));
    assign imemAddr = pcF_q;
    assign accept   = imemReq && imemValid;
    assign ready    = !validD_q || !stallD;

    assign instrD   = instrD_q;
    assign pcD      = pcD_q;
    assign pcPlus4D = pcPlus4D_q;
    assign validD   = validD_q;

    // Next-state logic: PC/state/skid/pending updates, then the IF/ID priority.
    always_comb begin
        state_d     = state_q;
        pcF_d       = pcF_q;
        skidInstr_d = skidInstr_q;
        skidPc_d    = skidPc_q;
        pendingPc_d = pendingPc_q;
        instrD_d    = instrD_q;
        pcD_d       = pcD_q;
        pcPlus4D_d  = pcPlus4D_q;
        validD_d    = validD_q;
        loadEn      = 1'b0;
        loadInstr   = imemRdata;
        loadPc      = pcF_q;

        case (state_q)
            FETCH: begin
                if (pcSrcE) begin
                    if (accept) begin
                        pcF_d = pcTargetE;
                    end else begin
                        pendingPc_d = pcTargetE;
                        state_d     = DROP;
                    end
                end else if (accept) begin
                    pcF_d = pcF_q + 32'd4;
                    if (ready) begin
                        loadEn    = 1'b1;
                        loadInstr = imemRdata;
                        loadPc    = pcF_q;
                    end else begin
                        skidInstr_d = imemRdata;
                        skidPc_d    = pcF_q;
                        state_d     = SKID;
                    end
                end
            end
            SKID: begin
                if (pcSrcE) begin
                    pcF_d   = pcTargetE;
                    state_d = FETCH;
                end else if (ready) begin
                    loadEn    = 1'b1;
                    loadInstr = skidInstr_q;
                    loadPc    = skidPc_q;
                    state_d   = FETCH;
                end
            end
            DROP: begin
                if (accept) begin
                    pcF_d   = pcSrcE ? pcTargetE : pendingPc_q;
                    state_d = FETCH;
                end else if (pcSrcE) begin
                    pendingPc_d = pcTargetE;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (pcSrcE) begin
            validD_d = 1'b0;
            instrD_d = NOP_INSTR;
        end else if (loadEn) begin
            validD_d   = 1'b1;
            instrD_d   = loadInstr;
            pcD_d      = loadPc;
            pcPlus4D_d = loadPc + 32'd4;
        end else if (validD_q && stallD) begin
            validD_d = validD_q;
        end else begin
            validD_d = 1'b0;
            instrD_d = NOP_INSTR;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pcF_q       <= RESET_PC;
            skidInstr_q <= 32'd0;
            skidPc_q    <= 32'd0;
            pendingPc_q <= 32'd0;
            instrD_q    <= NOP_INSTR;
            pcD_q       <= 32'd0;
            pcPlus4D_q  <= 32'd0;
            validD_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pcF_q       <= pcF_d;
            skidInstr_q <= skidInstr_d;
            skidPc_q    <= skidPc_d;
            pendingPc_q <= pendingPc_d;
            instrD_q    <= instrD_d;
            pcD_q       <= pcD_d;
            pcPlus4D_q  <= pcPlus4D_d;
            validD_q    <= validD_d;
        end
    end

endmodule
